// File: rtl/soma_seq_if.sv
// soma_seq_if: control, dendrite-sum stream, spike stream and config bus of the soma engine.
// master = sweep controller / upstream / config host, slave = soma_seq.
interface soma_seq_if #(
   parameter int unsigned NNW = 12,
   parameter int unsigned VW  = 20,
   parameter int unsigned RW  = 4
);
   logic                  start;
   logic [NNW-1:0]        base_addr;
   logic [NNW:0]          count;
   logic [1:0]            code;
   logic                  reset_mode;
   logic signed [VW-1:0]  vth;
   logic signed [VW-1:0]  leak;
   logic [RW-1:0]         refrac_period;
   logic                  sd_vm_valid;
   logic signed [VW-1:0]  sd_vm;
   logic                  sd_vm_ready;
   logic                  spk_valid;
   logic [NNW-1:0]        spk_addr;
   logic                  spk_ready;
   logic                  busy;
   logic                  done;
   logic                  cfg_vm_we;
   logic [NNW-1:0]        cfg_vm_waddr;
   logic signed [VW-1:0]  cfg_vm_wdata;
   logic                  cfg_vm_re;
   logic [NNW-1:0]        cfg_vm_raddr;
   logic signed [VW-1:0]  cfg_vm_rdata;

   modport master (
      output start, base_addr, count, code, reset_mode, vth, leak, refrac_period,
      output sd_vm_valid, sd_vm, spk_ready,
      output cfg_vm_we, cfg_vm_waddr, cfg_vm_wdata, cfg_vm_re, cfg_vm_raddr,
      input  sd_vm_ready, spk_valid, spk_addr, busy, done, cfg_vm_rdata
   );

   modport slave (
      input  start, base_addr, count, code, reset_mode, vth, leak, refrac_period,
      input  sd_vm_valid, sd_vm, spk_ready,
      input  cfg_vm_we, cfg_vm_waddr, cfg_vm_wdata, cfg_vm_re, cfg_vm_raddr,
      output sd_vm_ready, spk_valid, spk_addr, busy, done, cfg_vm_rdata
   );
endinterface

// File: rtl/soma_seq.sv
// soma_seq: sweeps a neuron address range, integrates dendrite sums with leak/threshold/reset,
// and streams out fired addresses. Membrane state lives in an internal memory that the config
// bus can access while idle.
// Optional feature: define SOMA_REFRACTORY_EN to store a refractory counter per neuron.
module soma_seq #(
   parameter int unsigned NNW = 12,
   parameter int unsigned VW  = 20,
   parameter int unsigned RW  = 4
) (
   input  logic       clk_soma,
   input  logic       rst_n,
   soma_seq_if.slave  bus
);
   localparam int unsigned EW    = VW + 2;
`ifdef SOMA_REFRACTORY_EN
   localparam int unsigned WW    = VW + RW;
`else
   localparam int unsigned WW    = VW;
`endif
   localparam int unsigned DEPTH = 32'd1 << NNW;

   typedef enum logic [2:0] {S_IDLE, S_READ, S_CALC, S_WRITE, S_SPIKE, S_DONE} state_t;

   state_t               r_state, w_state_nxt;
   logic [NNW-1:0]       r_base;
   logic [NNW:0]         r_count, r_idx;
   logic [WW-1:0]        r_mem [DEPTH];
   logic [WW-1:0]        r_rdata, r_wword;
   logic                 r_fire, r_busy, r_done, r_spk_valid, r_sd_ready;
   logic [NNW-1:0]       r_spk_addr;
   logic signed [VW-1:0] r_cfg_rdata;

   logic [NNW-1:0]       w_addr;
   logic [NNW:0]         w_idx_inc;
   logic                 w_last;
   logic signed [VW-1:0] w_vm, w_s, w_vm_new;
   logic signed [EW-1:0] w_sum, w_diff;
   logic                 w_fire;
   logic [WW-1:0]        w_word_new, w_cfg_word, w_wdata;
   logic                 w_we;
   logic [NNW-1:0]       w_waddr;

   // Clamp a widened result back into the VW-bit signed range
   function automatic logic signed [VW-1:0] f_sat(input logic signed [EW-1:0] x);
      logic signed [VW-1:0] y;
      if (x[EW-1:VW-1] == {(EW-VW+1){x[EW-1]}})
         y = x[VW-1:0];
      else if (x[EW-1])
         y = {1'b1, {(VW-1){1'b0}}};
      else
         y = {1'b0, {(VW-1){1'b1}}};
      return y;
   endfunction

   assign w_addr    = r_base + r_idx[NNW-1:0];   // wraps through 0
   assign w_idx_inc = r_idx + (NNW+1)'(1);
   assign w_last    = (w_idx_inc == r_count);

`ifdef SOMA_REFRACTORY_EN
   logic [RW-1:0] w_rc;
   assign w_cfg_word = {RW'(0), bus.cfg_vm_wdata};
`else
   logic w_unused_refrac;
   assign w_unused_refrac = ^bus.refrac_period;
   assign w_cfg_word      = bus.cfg_vm_wdata;
`endif

   // Neuron update: integrate, saturate, threshold, reset (and refractory gating)
   always_comb begin
      w_vm = r_rdata[VW-1:0];
      case (bus.code)
         2'b00:   w_sum = EW'(w_vm) + EW'(bus.sd_vm) - EW'(bus.leak);
         2'b01:   w_sum = EW'(w_vm) + EW'(bus.sd_vm);
         default: w_sum = EW'(w_vm);
      endcase
      w_s      = f_sat(w_sum);
      w_fire   = !bus.code[1] && (w_s >= bus.vth);
      w_diff   = EW'(w_s) - EW'(bus.vth);
      w_vm_new = w_s;
      if (w_fire)
         w_vm_new = bus.reset_mode ? f_sat(w_diff) : '0;
`ifdef SOMA_REFRACTORY_EN
      w_rc = r_rdata[WW-1:VW];
      if (w_rc != '0) begin
         w_fire     = 1'b0;
         w_word_new = {w_rc - RW'(1), w_vm};
      end else begin
         w_word_new = {(w_fire ? bus.refrac_period : RW'(0)), w_vm_new};
      end
`else
      w_word_new = w_vm_new;
`endif
   end

   // State register
   always_ff @(posedge clk_soma or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = (bus.count == '0) ? S_DONE : S_READ;
         S_READ:  w_state_nxt = S_CALC;
         S_CALC:  if (bus.sd_vm_valid) w_state_nxt = S_WRITE;
         S_WRITE: begin
            if (r_fire)      w_state_nxt = S_SPIKE;
            else if (w_last) w_state_nxt = S_DONE;
            else             w_state_nxt = S_READ;
         end
         S_SPIKE: if (bus.spk_ready) w_state_nxt = w_last ? S_DONE : S_READ;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Sweep bookkeeping and the computed word awaiting write-back
   always_ff @(posedge clk_soma or negedge rst_n) begin
      if (!rst_n) begin
         r_base  <= '0;
         r_count <= '0;
         r_idx   <= '0;
         r_wword <= '0;
         r_fire  <= 1'b0;
      end else begin
         if (r_state == S_IDLE && bus.start) begin
            r_base  <= bus.base_addr;
            r_count <= bus.count;
            r_idx   <= '0;
         end
         if (r_state == S_CALC && bus.sd_vm_valid) begin
            r_wword <= w_word_new;
            r_fire  <= w_fire;
         end
         if ((r_state == S_WRITE && !r_fire) || (r_state == S_SPIKE && bus.spk_ready))
            r_idx <= w_idx_inc;
      end
   end

   // Registered outputs, derived from the upcoming state
   always_ff @(posedge clk_soma or negedge rst_n) begin
      if (!rst_n) begin
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_sd_ready  <= 1'b0;
         r_spk_valid <= 1'b0;
         r_spk_addr  <= '0;
         r_cfg_rdata <= '0;
      end else begin
         r_busy      <= (w_state_nxt != S_IDLE);
         r_done      <= (w_state_nxt == S_DONE);
         r_sd_ready  <= (w_state_nxt == S_CALC);
         r_spk_valid <= (w_state_nxt == S_SPIKE);
         if (r_state == S_WRITE && r_fire)
            r_spk_addr <= w_addr;
         if (r_state == S_IDLE && bus.cfg_vm_re)
            r_cfg_rdata <= r_mem[bus.cfg_vm_raddr][VW-1:0];
      end
   end

   // Memory write arbitration: engine owns the port while busy, config bus while idle
   assign w_we    = (r_state == S_WRITE) || (r_state == S_IDLE && bus.cfg_vm_we);
   assign w_waddr = (r_state == S_WRITE) ? w_addr  : bus.cfg_vm_waddr;
   assign w_wdata = (r_state == S_WRITE) ? r_wword : w_cfg_word;

   // Membrane memory; not cleared by reset
   always_ff @(posedge clk_soma) begin
      if (w_we)
         r_mem[w_waddr] <= w_wdata;
      if (r_state == S_READ)
         r_rdata <= r_mem[w_addr];
   end

   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.sd_vm_ready  = r_sd_ready;
   assign bus.spk_valid    = r_spk_valid;
   assign bus.spk_addr     = r_spk_addr;
   assign bus.cfg_vm_rdata = r_cfg_rdata;
endmodule
